// File: rtl/de_aes_pkg.sv
// Shared constants and state encoding for the AES-128 decryption round sequencer.
package de_aes_pkg;

  localparam int unsigned DefNr       = 10;
  localparam int unsigned DefRoundLat = 2;
  localparam int unsigned DefFinalLat = 1;
  localparam int unsigned DefKaw      = 4;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StRound = 2'd1,
    StFinal = 2'd2,
    StDone  = 2'd3
  } state_e;

  // Width of a counter that must reach the larger of two stage latencies.
  function automatic int unsigned lat_width(input int unsigned a, input int unsigned b);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m < 1) ? 1 : $clog2(m + 1);
  endfunction

endpackage

// File: rtl/de_round_timer.sv
// Round down-counter and per-stage latency counter for the decryption sequencer.
module de_round_timer
  import de_aes_pkg::*;
#(
  parameter int unsigned NR        = DefNr,
  parameter int unsigned ROUND_LAT = DefRoundLat,
  parameter int unsigned FINAL_LAT = DefFinalLat,
  parameter int unsigned KAW       = DefKaw
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           i_clear,
  input  logic           i_load,
  input  logic           i_run,
  input  logic           i_final,
  output logic [KAW-1:0] o_rnd,
  output logic           o_last_cycle,
  output logic           o_last_round
);

  localparam int unsigned LatW = lat_width(ROUND_LAT, FINAL_LAT);

  logic [KAW-1:0]  r_rnd;
  logic [LatW-1:0] r_lat;
  logic [LatW-1:0] w_lat_max;

  assign w_lat_max    = i_final ? LatW'(FINAL_LAT) : LatW'(ROUND_LAT);
  assign o_last_cycle = (r_lat == w_lat_max);
  assign o_last_round = (r_rnd == KAW'(1));
  assign o_rnd        = r_rnd;

  // Latency counter wraps at the stage boundary; round index steps down only between rounds
  // and stops at 1 so key index 0 is reserved for the final stage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rnd <= '0;
      r_lat <= '0;
    end else if (i_clear) begin
      r_rnd <= '0;
      r_lat <= '0;
    end else if (i_load) begin
      r_rnd <= KAW'(NR - 1);
      r_lat <= '0;
    end else if (i_run) begin
      if (o_last_cycle) begin
        r_lat <= '0;
        if (!i_final && !o_last_round) begin
          r_rnd <= r_rnd - KAW'(1);
        end
      end else begin
        r_lat <= r_lat + LatW'(1);
      end
    end
  end

endmodule

// File: rtl/de_round_ctrl.sv
// Iterative AES-128 decryption sequencer driving shared inverse-round and final-round datapaths.
module de_round_ctrl
  import de_aes_pkg::*;
#(
  parameter int unsigned NR        = DefNr,
  parameter int unsigned ROUND_LAT = DefRoundLat,
  parameter int unsigned FINAL_LAT = DefFinalLat,
  parameter int unsigned KAW       = DefKaw
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           iClear,
  input  logic           iValid,
  output logic           oReady,
  input  logic [127:0]   iBlockIn,
  output logic [KAW-1:0] oKeyAddr,
  input  logic [127:0]   iKeyValue,
  output logic [127:0]   oRoundBlock,
  output logic [127:0]   oRoundKey,
  input  logic [127:0]   iRoundOut,
  output logic [127:0]   oFinalBlock,
  input  logic [127:0]   iFinalOut,
  output logic           oValid,
  input  logic           iReady,
  output logic [127:0]   oBlockOut,
  output logic           oBusy
);

  state_e         r_state;
  logic [127:0]   r_blk;
  logic           r_valid;
  logic [127:0]   r_block_out;

  logic [KAW-1:0] w_rnd;
  logic           w_last_cycle;
  logic           w_last_round;
  logic           w_accept;
  logic           w_run;
  logic           w_final;

  assign w_accept = (r_state == StIdle) && iValid && !iClear;
  assign w_run    = (r_state == StRound) || (r_state == StFinal);
  assign w_final  = (r_state == StFinal);

  de_round_timer #(
    .NR        (NR),
    .ROUND_LAT (ROUND_LAT),
    .FINAL_LAT (FINAL_LAT),
    .KAW       (KAW)
  ) u_timer (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_clear      (iClear),
    .i_load       (w_accept),
    .i_run        (w_run),
    .i_final      (w_final),
    .o_rnd        (w_rnd),
    .o_last_cycle (w_last_cycle),
    .o_last_round (w_last_round)
  );

  // Sequencer FSM with registered state block and plaintext output.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= StIdle;
      r_blk       <= '0;
      r_valid     <= 1'b0;
      r_block_out <= '0;
    end else if (iClear) begin
      r_state <= StIdle;
      r_valid <= 1'b0;
    end else begin
      case (r_state)
        StIdle: begin
          if (iValid) begin
            r_blk   <= iBlockIn ^ iKeyValue;
            r_state <= StRound;
          end
        end
        StRound: begin
          if (w_last_cycle) begin
            r_blk <= iRoundOut;
            if (w_last_round) begin
              r_state <= StFinal;
            end
          end
        end
        StFinal: begin
          if (w_last_cycle) begin
            r_block_out <= iFinalOut;
            r_valid     <= 1'b1;
            r_state     <= StDone;
          end
        end
        StDone: begin
          if (iReady) begin
            r_valid <= 1'b0;
            r_state <= StIdle;
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  // Key address and datapath operands; idle datapath inputs are forced to zero.
  always_comb begin
    oKeyAddr    = '0;
    oRoundBlock = '0;
    oFinalBlock = '0;
    case (r_state)
      StIdle:  oKeyAddr = KAW'(NR);
      StRound: begin
        oKeyAddr    = w_rnd;
        oRoundBlock = r_blk;
      end
      StFinal: oFinalBlock = r_blk;
      default: oKeyAddr = '0;
    endcase
  end

  assign oRoundKey = iKeyValue;
  assign oReady    = (r_state == StIdle);
  assign oBusy     = (r_state != StIdle);
  assign oValid    = r_valid;
  assign oBlockOut = r_block_out;

endmodule

// File: tb/tb_de_round_ctrl.sv
// Scoreboard bench for de_round_ctrl with behavioural AES inverse-round datapaths.
module tb_de_round_ctrl;

  localparam logic [127:0] KeyA  = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] CtC1  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] PtC1  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] KeyB  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] CtB   = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] PtB   = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] Ct1   = 128'h3ad77bb40d7a3660a89ecaf32466ef97;
  localparam logic [127:0] Pt1   = 128'h6bc1bee22e409f96e93d7e117393172a;
  localparam logic [127:0] Ct2   = 128'hf5d3d58503b9699de785895a96fdbaaf;
  localparam logic [127:0] Pt2   = 128'hae2d8a571e03ac9c9eb76fac45af8e51;
  localparam logic [127:0] Ct3   = 128'h43b1cd7f598ece23881b00e3ed030688;
  localparam logic [127:0] Pt3   = 128'h30c81c46a35ce411e5fbc1191a0a52ef;
  localparam logic [127:0] Ct4   = 128'h7b0c785e27e8ad3f8223207104725dd4;
  localparam logic [127:0] Pt4   = 128'hf69f2445df4f9b17ad2b417be66c3710;

  logic         clk = 1'b0;
  logic         rst_n, iClear, iValid, oReady, oValid, iReady, oBusy;
  logic [127:0] iBlockIn, iKeyValue, oRoundBlock, oRoundKey, iRoundOut;
  logic [127:0] oFinalBlock, iFinalOut, oBlockOut;
  logic [3:0]   oKeyAddr;

  int n_chk = 0;
  int n_err = 0;
  int cyc_cnt = 0;
  logic [127:0] sb_q [$];
  int out_cyc [$];

  logic [7:0]   sb_t  [256];
  logic [7:0]   isb_t [256];
  logic [127:0] keytab [16];
  logic [127:0] rd_s1, rd_s2, fd_s1;

  de_round_ctrl u_dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .iClear      (iClear),
    .iValid      (iValid),
    .oReady      (oReady),
    .iBlockIn    (iBlockIn),
    .oKeyAddr    (oKeyAddr),
    .iKeyValue   (iKeyValue),
    .oRoundBlock (oRoundBlock),
    .oRoundKey   (oRoundKey),
    .iRoundOut   (iRoundOut),
    .oFinalBlock (oFinalBlock),
    .iFinalOut   (iFinalOut),
    .oValid      (oValid),
    .iReady      (iReady),
    .oBlockOut   (oBlockOut),
    .oBusy       (oBusy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  // ---------------- AES helpers ----------------
  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x, y;
    p = 8'h00; x = a; y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p = p ^ x;
      x = xtime(x);
      y = y >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
    return (x << n) | (x >> (8 - n));
  endfunction

  function automatic logic [7:0] sbox_f(input logic [7:0] a);
    logic [7:0] r;
    r = 8'h01;
    for (int i = 0; i < 254; i++) r = gmul(r, a);
    return r ^ rotl8(r, 1) ^ rotl8(r, 2) ^ rotl8(r, 3) ^ rotl8(r, 4) ^ 8'h63;
  endfunction

  function automatic logic [7:0] gb(input logic [127:0] s, input int i);
    return s[127-8*i -: 8];
  endfunction

  function automatic logic [7:0] coef(input int i);
    case (i)
      0: return 8'h0e;
      1: return 8'h0b;
      2: return 8'h0d;
      default: return 8'h09;
    endcase
  endfunction

  // InvShiftRows followed by InvSubBytes.
  function automatic logic [127:0] inv_ss(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        o[127-8*(r+4*c) -: 8] = isb_t[gb(s, r + 4*((c - r + 4) % 4))];
    return o;
  endfunction

  function automatic logic [127:0] inv_mc(input logic [127:0] s);
    logic [127:0] o;
    logic [7:0]   b;
    o = '0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++) begin
        b = 8'h00;
        for (int k = 0; k < 4; k++) b = b ^ gmul(gb(s, k + 4*c), coef((k - r + 4) % 4));
        o[127-8*(r+4*c) -: 8] = b;
      end
    return o;
  endfunction

  task automatic load_key(input logic [127:0] key);
    logic [31:0] w [44];
    logic [31:0] t;
    logic [7:0]  rcon;
    rcon = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sb_t[t[31:24]], sb_t[t[23:16]], sb_t[t[15:8]], sb_t[t[7:0]]};
        t[31:24] = t[31:24] ^ rcon;
        rcon = xtime(rcon);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int k = 0; k < 16; k++) begin
      if (k <= 10) keytab[k] = {w[4*k], w[4*k+1], w[4*k+2], w[4*k+3]};
      else keytab[k] = '0;
    end
  endtask

  // Key table read port and the two external datapaths (2-stage round, 1-stage final).
  assign iKeyValue = keytab[oKeyAddr];
  always @(posedge clk) begin
    rd_s1 <= inv_ss(oRoundBlock);
    rd_s2 <= inv_mc(rd_s1 ^ oRoundKey);
    fd_s1 <= inv_ss(oFinalBlock) ^ oRoundKey;
  end
  assign iRoundOut = rd_s2;
  assign iFinalOut = fd_s1;

  // ---------------- checking ----------------
  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: samples after the stimulus has settled each cycle's inputs.
  initial begin
    logic [127:0] e;
    forever begin
      @(negedge clk);
      #2;
      if (rst_n && oValid && iReady) begin
        if (sb_q.size() == 0) begin
          chk("unexpected plaintext", oBlockOut, 128'h0);
        end else begin
          e = sb_q.pop_front();
          chk("plaintext", oBlockOut, e);
        end
        out_cyc.push_back(cyc_cnt);
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic start(input logic [127:0] ct, input logic [127:0] pt);
    int n;
    iValid = 1'b1;
    iBlockIn = ct;
    sb_q.push_back(pt);
    n = 0;
    while (!oReady && n < 100) begin tick(); n++; end
    chk("oReady before accept", 128'(oReady), 128'h1);
    tick();
    iValid = 1'b0;
  endtask

  task automatic wait_valid();
    int n;
    n = 0;
    while (!oValid && n < 100) begin tick(); n++; end
    chk("oValid within bound", 128'(oValid), 128'h1);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb_q.size() != 0 && n < 200) begin tick(); n++; end
    chk("scoreboard drained", 128'(sb_q.size()), 128'h0);
    tick();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [127:0] prev_rb;
    int lat, saw, n, base;
    int acc [3];

    rst_n = 1'b0; iClear = 1'b0; iValid = 1'b0; iReady = 1'b1; iBlockIn = '0;
    for (int i = 0; i < 256; i++) sb_t[i] = sbox_f(8'(i));
    for (int i = 0; i < 256; i++) isb_t[sb_t[i]] = 8'(i);
    load_key(KeyA);
    repeat (3) tick();
    chk("reset oValid", 128'(oValid), 128'h0);
    chk("reset oBlockOut", oBlockOut, 128'h0);
    rst_n = 1'b1;
    tick();
    chk("reset oReady", 128'(oReady), 128'h1);
    chk("reset oBusy", 128'(oBusy), 128'h0);
    chk("reset oRoundBlock", oRoundBlock, 128'h0);
    chk("reset oFinalBlock", oFinalBlock, 128'h0);

    // FIPS-197 C.1 with key-address trace and latency.
    iValid = 1'b1;
    iBlockIn = CtC1;
    sb_q.push_back(PtC1);
    chk("idle key addr", 128'(oKeyAddr), 128'd10);
    lat = 0;
    prev_rb = '0;
    for (int j = 1; j <= 40; j++) begin
      tick();
      if (j == 1) iValid = 1'b0;
      if (oValid) begin lat = j; break; end
      chk("key addr", 128'(oKeyAddr), (j <= 27) ? 128'(9 - (j - 1) / 3) : 128'h0);
      if (j <= 27 && (j - 1) % 3 != 0) chk("round block stable", oRoundBlock, prev_rb);
      if (j == 1) chk("final block zero in round", oFinalBlock, 128'h0);
      if (j == 28) chk("round block zero in final", oRoundBlock, 128'h0);
      prev_rb = oRoundBlock;
    end
    // Set on edge 29 after accept; first visible at the sample after that edge.
    chk("accept to oValid", 128'(lat), 128'd30);
    drain();

    // Abort during round 5, then a clean decrypt.
    start(CtC1, PtC1);
    n = 0;
    while (oKeyAddr != 4'd5 && n < 100) begin tick(); n++; end
    chk("reach round 5", 128'(oKeyAddr), 128'd5);
    iClear = 1'b1;
    tick();
    iClear = 1'b0;
    sb_q.delete();
    chk("abort oReady", 128'(oReady), 128'h1);
    chk("abort oBusy", 128'(oBusy), 128'h0);
    saw = 0;
    repeat (40) begin tick(); if (oValid) saw = 1; end
    chk("no oValid after abort", 128'(saw), 128'h0);
    start(CtC1, PtC1);
    wait_valid();
    drain();

    // Asynchronous reset during FINAL.
    start(CtC1, PtC1);
    n = 0;
    while (!(oBusy && oKeyAddr == 4'd0) && n < 100) begin tick(); n++; end
    chk("reach final", 128'(oBusy && oKeyAddr == 4'd0), 128'h1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async reset oValid", 128'(oValid), 128'h0);
    chk("async reset oBlockOut", oBlockOut, 128'h0);
    chk("async reset oBusy", 128'(oBusy), 128'h0);
    sb_q.delete();
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    chk("post reset oReady", 128'(oReady), 128'h1);
    start(CtC1, PtC1);
    wait_valid();
    drain();

    // Output backpressure with a queued second block.
    load_key(KeyB);
    tick();
    iReady = 1'b0;
    start(Ct1, Pt1);
    wait_valid();
    iValid = 1'b1;
    iBlockIn = Ct2;
    sb_q.push_back(Pt2);
    for (int k = 0; k < 10; k++) begin
      chk("held oValid", 128'(oValid), 128'h1);
      chk("held oBlockOut", oBlockOut, Pt1);
      chk("held oReady", 128'(oReady), 128'h0);
      tick();
    end
    iReady = 1'b1;
    tick();
    iReady = 1'b0;
    chk("idle after handoff", 128'(oReady), 128'h1);
    chk("no accept at handoff", 128'(oBusy), 128'h0);
    tick();
    iValid = 1'b0;
    chk("queued block accepted", 128'(oBusy), 128'h1);
    chk("queued block round key", 128'(oKeyAddr), 128'd9);
    iReady = 1'b1;
    wait_valid();
    drain();

    // Back-to-back with iValid held and iReady tied high.
    base = out_cyc.size();
    iValid = 1'b1;
    for (int b = 0; b < 3; b++) begin
      case (b)
        0: begin iBlockIn = CtB; sb_q.push_back(PtB); end
        1: begin iBlockIn = Ct3; sb_q.push_back(Pt3); end
        default: begin iBlockIn = Ct4; sb_q.push_back(Pt4); end
      endcase
      n = 0;
      while (!oReady && n < 100) begin tick(); n++; end
      chk("b2b ready", 128'(oReady), 128'h1);
      acc[b] = cyc_cnt;
      tick();
    end
    iValid = 1'b0;
    drain();
    chk("b2b accept spacing 1", 128'(acc[1] - acc[0]), 128'd31);
    chk("b2b accept spacing 2", 128'(acc[2] - acc[1]), 128'd31);
    chk("b2b outputs seen", 128'(out_cyc.size() - base), 128'd3);
    if (out_cyc.size() - base == 3) begin
      chk("b2b output spacing 1", 128'(out_cyc[base+1] - out_cyc[base]), 128'd31);
      chk("b2b output spacing 2", 128'(out_cyc[base+2] - out_cyc[base+1]), 128'd31);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/de_round_ctrl.md
Name: de_round_ctrl

Overview:
Iterative AES-128 decryption sequencer. It takes one ciphertext block per transaction and performs the initial AddRoundKey internally. It then drives the single shared two-stage inverse round datapath (InvShiftRows/InvSubBytes, then AddRoundKey/InvMixColumns) for rounds NR-1 down to 1, followed by one pass through the final-round datapath (no InvMixColumns). Round keys come from an external expanded-key table through a combinational read port; the plaintext is returned over a valid/ready output handshake.

Parameters:
NR, 10, number of AES rounds; the initial key index is NR.
ROUND_LAT, 2, register stages in the shared inverse round datapath.
FINAL_LAT, 1, register stages in the final-round datapath.
KAW, 4, key-table address width; must satisfy 2^KAW > NR.

Ports:
clk  in  1  clock; all state updates on the rising edge.
rst_n  in  1  asynchronous active-low reset.
iClear  in  1  synchronous abort; forces IDLE.
iValid  in  1  input block valid.
oReady  out  1  controller can accept a block; high only in IDLE.
iBlockIn  in  128  ciphertext.
oKeyAddr  out  KAW  expanded-key table read address.
iKeyValue  in  128  round key at oKeyAddr, combinational.
oRoundBlock  out  128  state block driven into the shared round datapath.
oRoundKey  out  128  round key driven into the shared round datapath (equals iKeyValue).
iRoundOut  in  128  round datapath result.
oFinalBlock  out  128  state block driven into the final-round datapath.
iFinalOut  in  128  final-round datapath result.
oValid  out  1  plaintext valid.
iReady  in  1  downstream accepts plaintext.
oBlockOut  out  128  plaintext, registered.
oBusy  out  1  high in every state except IDLE.

Behaviour:
- Reset values (rst_n low, asynchronous): state IDLE; all state, round and latency registers 0; oValid 0; oBlockOut 0; oBusy 0; oReady 1 once reset is released.
- States: IDLE, ROUND, FINAL, DONE.
- IDLE:
  - oKeyAddr = NR.
  - Accept when iValid && oReady: blk <= iBlockIn ^ iKeyValue; rnd <= NR-1; lat <= 0; go to ROUND.
- ROUND:
  - oRoundBlock = blk; oKeyAddr = rnd. Both are held constant for all ROUND_LAT+1 cycles of the round.
  - lat increments each cycle.
  - When lat == ROUND_LAT: blk <= iRoundOut; lat <= 0.
    - If rnd == 1, go to FINAL with oKeyAddr = 0.
    - Otherwise rnd <= rnd-1 and stay in ROUND.
- FINAL:
  - oFinalBlock = blk; oKeyAddr = 0, held constant.
  - When lat == FINAL_LAT: oBlockOut <= iFinalOut; oValid <= 1; go to DONE.
- DONE:
  - oBlockOut and oValid are held until iReady.
  - On iValid... no: on iReady, oValid <= 0 and go to IDLE.
  - No new block is accepted in the same cycle as the iReady handoff.
- Latency: from the accept edge to oValid high is (NR-1)*(ROUND_LAT+1)+(FINAL_LAT+1) edges, which is 29 with the defaults.
- Throughput: one block per latency+2 cycles.
- When not in ROUND, oRoundBlock = 0; when not in FINAL, oFinalBlock = 0. This keeps idle datapath toggling deterministic.
- oRoundKey = iKeyValue at all times. The key must stay stable for the whole round because the datapath's second stage samples it.
- iClear has priority over every transition: next state IDLE; oValid 0; counters 0; oBlockOut keeps its value.
- iValid is ignored outside IDLE; the upstream block is held until oReady.
- rnd never wraps. The ROUND to FINAL transition is decided at rnd == 1, so key index 0 is never used in ROUND.
- Reset asserted mid-operation discards the block immediately; outputs return to reset values.

Decomposition:
- Package de_aes_pkg: NR, ROUND_LAT, FINAL_LAT and KAW defaults, plus the state encoding (IDLE=0, ROUND=1, FINAL=2, DONE=3).
- One sub-module, de_round_timer: the rnd down-counter and the lat counter. Its outputs are last_cycle (lat == current stage latency) and last_round (rnd == 1). It takes a stage-select input to choose ROUND_LAT or FINAL_LAT.

Test Plan:
- FIPS-197 C.1 vector. Key table expanded from 000102030405060708090a0b0c0d0e0f; iBlockIn = 69c4e0d86a7b0430d8cdb78070b4c55a; real datapaths bound. Required: oBlockOut = 00112233445566778899aabbccddeeff, with oValid rising exactly 29 edges after accept.
- Key-address sequence check. oKeyAddr = 10 in the accept cycle, then 9 down to 1, each held for 3 cycles, then 0 for 2 cycles. oRoundBlock is stable within each round.
- Output backpressure. Hold iReady = 0 for 10 cycles after oValid. Required: oValid and oBlockOut stay stable and oReady stays 0. Then pulse iReady: IDLE follows, and a queued second block is accepted one cycle later.
- Abort. Assert iClear in round 5. Required: IDLE next cycle, oReady 1, and oValid never asserts. A new block then decrypts correctly.
- Reset. Pulse rst_n low asynchronously mid-FINAL. Required: oValid 0, oBlockOut 0 and oBusy 0 immediately; correct operation after release.
- Back-to-back. Hold iValid high with iReady tied to 1 for 3 blocks. Required: 3 correct plaintexts, each 31 cycles apart.
